// File: rtl/mmff_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmff_cfg_pkg
//  Description : Shared types and constants for the MMFF configuration chain
//                controller: FSM state encoding, CRC-8 parameters and a
//                single-bit CRC update helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmff_cfg_pkg;

    // Width of one flip-flop mode select held in the chain.
    localparam int         MODE_W    = 4;

    // CRC-8, polynomial x^8+x^2+x+1, zero init, no reflection, no xorout.
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Advance a serial CRC-8 by one input bit (MSB-first feedback form).
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmff_cfg_chain_ctrl_crc8_serial.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_serial
//  Description : One-bit-per-clock CRC-8 accumulator with synchronous clear
//                and enable. Clear takes priority over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_serial
    import mmff_cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc_o
);

    logic [7:0] crc_d;
    logic [7:0] crc_q;

    // Next CRC value: clear, consume one bit, or hold.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC8_INIT;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    // CRC register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/mmff_cfg_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmff_cfg_chain_ctrl
//  Description : Loads a column CCFF chain from a word stream (LSB first),
//                then recirculates the chain once and compares a CRC-8 of
//                the recirculated bits with the CRC taken during load.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmff_cfg_chain_ctrl
    import mmff_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              ccff_head_o,
    output logic              ccff_shift_en_o,
    input  logic              ccff_tail_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cfg_locked_o
);

    localparam int NUM_WORDS = CHAIN_LEN / WORD_W;
    localparam int WC_W      = $clog2(NUM_WORDS + 1);
    localparam int BC_W      = $clog2(WORD_W + 1);
    localparam int VC_W      = $clog2(CHAIN_LEN + 1);

    localparam logic [WC_W-1:0] C_NUM_WORDS = WC_W'(NUM_WORDS);
    localparam logic [BC_W-1:0] C_WORD_W    = BC_W'(WORD_W);
    localparam logic [VC_W-1:0] C_CHAIN_LEN = VC_W'(CHAIN_LEN);

    state_e            state_q,      state_d;
    logic [WORD_W-1:0] buf_q,        buf_d;
    logic [BC_W-1:0]   bits_left_q,  bits_left_d;
    logic [WC_W-1:0]   words_left_q, words_left_d;
    logic [VC_W-1:0]   vcount_q,     vcount_d;
    logic              err_q,        err_d;
    logic              locked_q,     locked_d;

    logic              w_ready;
    logic              w_shift;
    logic              w_head;
    logic              w_done;
    logic              w_crc_l_clr;
    logic              w_crc_v_clr;
    logic              w_crc_v_en;
    logic [7:0]        w_crc_l;
    logic [7:0]        w_crc_v;

    // Next-state, datapath and output decode for the load/verify sequence.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        bits_left_d  = bits_left_q;
        words_left_d = words_left_q;
        vcount_d     = vcount_q;
        err_d        = err_q;
        locked_d     = locked_q;
        w_ready      = 1'b0;
        w_shift      = 1'b0;
        w_head       = 1'b0;
        w_done       = 1'b0;
        w_crc_l_clr  = 1'b0;
        w_crc_v_clr  = 1'b0;
        w_crc_v_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_LOAD;
                    err_d        = 1'b0;
                    locked_d     = 1'b0;
                    w_crc_l_clr  = 1'b1;
                    words_left_d = C_NUM_WORDS;
                    bits_left_d  = '0;
                end
            end
            ST_LOAD: begin
                // Ready while the last bit of the current word is going out,
                // so consecutive words stream with no idle shift cycle.
                w_ready = (bits_left_q <= BC_W'(1)) && (words_left_q != '0);
                w_shift = (bits_left_q != '0);
                w_head  = buf_q[0];
                if (w_shift) begin
                    buf_d       = buf_q >> 1;
                    bits_left_d = bits_left_q - 1'b1;
                end
                if (w_ready && data_valid_i) begin
                    buf_d        = data_i;
                    bits_left_d  = C_WORD_W;
                    words_left_d = words_left_q - 1'b1;
                end
                if (w_shift && (bits_left_q == BC_W'(1)) && (words_left_q == '0)) begin
                    state_d     = ST_VERIFY;
                    vcount_d    = C_CHAIN_LEN;
                    w_crc_v_clr = 1'b1;
                end
            end
            ST_VERIFY: begin
                // Tail fed back to head: a full lap leaves the chain unchanged.
                w_shift    = 1'b1;
                w_head     = ccff_tail_i;
                w_crc_v_en = 1'b1;
                vcount_d   = vcount_q - 1'b1;
                if (vcount_q == VC_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (w_crc_v == w_crc_l) begin
                    locked_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            bits_left_q  <= '0;
            words_left_q <= '0;
            vcount_q     <= '0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            bits_left_q  <= bits_left_d;
            words_left_q <= words_left_d;
            vcount_q     <= vcount_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
        end
    end

    // CRC of the bits written into the chain head during load.
    crc8_serial u_crc_load (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (w_crc_l_clr),
        .en     (w_shift && (state_q == ST_LOAD)),
        .bit_in (buf_q[0]),
        .crc_o  (w_crc_l)
    );

    // CRC of the bits read from the chain tail during recirculation.
    crc8_serial u_crc_verify (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (w_crc_v_clr),
        .en     (w_crc_v_en),
        .bit_in (ccff_tail_i),
        .crc_o  (w_crc_v)
    );

    assign data_ready_o    = w_ready;
    assign ccff_head_o     = w_head;
    assign ccff_shift_en_o = w_shift;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = w_done;
    assign err_o           = err_q;
    assign cfg_locked_o    = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_mmff_cfg_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmff_cfg_chain_ctrl
//  Description : Scoreboard bench for mmff_cfg_chain_ctrl with a 32-bit CCFF
//                chain model. Stimulus pushes expected sequence results; a
//                monitor pops and compares on each done_o pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mmff_cfg_chain_ctrl;

    localparam int CHAIN_LEN = 32;
    localparam int WORD_W    = 8;
    localparam int NWORDS    = CHAIN_LEN / WORD_W;
    // Stream A5,3C,FF,01 LSB first; first bit lands at position 31.
    localparam logic [31:0] C_EXP_CHAIN = 32'hA53C_FF80;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [WORD_W-1:0] data_i = '0;
    logic              data_valid_i = 1'b0;
    logic              data_ready_o;
    logic              ccff_head_o;
    logic              ccff_shift_en_o;
    logic              ccff_tail_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              cfg_locked_o;

    logic [31:0]       chain = '0;
    logic              flip_req = 1'b0;
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_bad = 0;
    int                sc = 0;

    typedef struct {
        int          done_cyc;
        int          shifts;
        bit          locked;
        bit          err;
        bit          chk_chain;
        logic [31:0] chain;
    } exp_t;

    exp_t              exp_q[$];
    logic [7:0]        words [NWORDS] = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

    mmff_cfg_chain_ctrl #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .data_i          (data_i),
        .data_valid_i    (data_valid_i),
        .data_ready_o    (data_ready_o),
        .ccff_head_o     (ccff_head_o),
        .ccff_shift_en_o (ccff_shift_en_o),
        .ccff_tail_i     (ccff_tail_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .cfg_locked_o    (cfg_locked_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: head enters bit 0, tail is bit 31; optional single-bit upset.
    always @(posedge clk) begin : chain_model
        logic [31:0] nx;
        nx = chain;
        if (ccff_shift_en_o) nx = {chain[30:0], ccff_head_o};
        if (flip_req) nx[15] = ~nx[15];
        chain <= nx;
    end

    assign ccff_tail_i = chain[31];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: counts shifts and checks each completed sequence against the queue.
    always begin
        @(negedge clk);
        if (rst_i) begin
            sc = 0;
        end else begin
            if (ccff_shift_en_o) sc++;
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: done_o=1 at cycle %0d, expected no done", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("shift_count", sc, e.shifts);
                    @(negedge clk);
                    chk("done_pulse_width", done_o, 1'b0);
                    chk("cfg_locked", cfg_locked_o, e.locked);
                    chk("err", err_o, e.err);
                    chk("busy_after_done", busy_o, 1'b0);
                    if (e.chk_chain) chk("chain_contents", chain, e.chain);
                end
                sc = 0;
            end
        end
    end

    // Issue start, optionally push the expected result, and feed the four words.
    task automatic run_seq(input int gap_len, input bit do_push, input bit fault, output int t0);
        int idx;
        int gap;
        int guard;
        idx   = 0;
        gap   = gap_len;
        guard = 0;
        @(negedge clk);
        start_i = 1'b1;
        t0 = cyc;
        if (do_push) begin
            exp_t e;
            e.done_cyc  = t0 + 2 * CHAIN_LEN + 2 + gap_len;
            e.shifts    = 2 * CHAIN_LEN;
            e.locked    = !fault;
            e.err       = fault;
            e.chk_chain = !fault;
            e.chain     = C_EXP_CHAIN;
            exp_q.push_back(e);
        end
        while (idx < NWORDS && guard < 200) begin
            @(negedge clk);
            if (guard == 0) start_i = 1'b0;
            guard++;
            if (!busy_o) break;
            if (idx == 2 && gap > 0 && data_ready_o) begin
                data_valid_i = 1'b0;
                gap--;
            end else begin
                data_valid_i = 1'b1;
                data_i       = words[idx];
            end
            if (data_valid_i && data_ready_o) idx++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL feed_timeout: accepted %0d words, expected %0d", idx, NWORDS);
        end
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    // Wait (bounded) for the controller to go idle and the scoreboard to drain.
    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy_o || exp_q.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (g >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle with none pending",
                     busy_o, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk("in_reset_outputs", {data_ready_o, ccff_head_o, ccff_shift_en_o, busy_o,
                                 done_o, err_o, cfg_locked_o}, 7'b0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", {data_ready_o, ccff_head_o, ccff_shift_en_o, busy_o,
                                   done_o, err_o, cfg_locked_o}, 7'b0);

        // Valid outside LOAD must not be accepted or start anything.
        data_valid_i = 1'b1;
        data_i       = 8'h55;
        repeat (2) @(negedge clk);
        chk("idle_ignores_valid", {data_ready_o, ccff_shift_en_o, busy_o}, 3'b000);
        data_valid_i = 1'b0;

        // Clean load, valid always available.
        run_seq(0, 1'b1, 1'b0, t0);
        wait_idle();

        // Five-cycle data gap between the second and third words.
        run_seq(5, 1'b1, 1'b0, t0);
        wait_idle();

        // Start pulses during an active sequence are dropped.
        fork
            run_seq(0, 1'b1, 1'b0, t0);
            begin
                repeat (11) @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
                repeat (29) @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        join
        wait_idle();

        // Single-bit upset in the chain during verify.
        fork
            run_seq(0, 1'b1, 1'b1, t0);
            begin
                repeat (39) @(negedge clk);
                flip_req = 1'b1;
                @(negedge clk);
                flip_req = 1'b0;
            end
        join
        wait_idle();

        // New start after an error clears err on the start edge.
        fork
            run_seq(0, 1'b1, 1'b0, t0);
            begin
                repeat (2) @(negedge clk);
                chk("err_clear_on_start", err_o, 1'b0);
                chk("busy_after_start", busy_o, 1'b1);
            end
        join
        wait_idle();

        // Reset in the middle of LOAD aborts the sequence.
        fork
            run_seq(0, 1'b0, 1'b0, t0);
            begin
                repeat (16) @(negedge clk);
                rst_i = 1'b1;
                @(negedge clk);
                chk("reset_abort_outputs", {data_ready_o, ccff_head_o, ccff_shift_en_o, busy_o,
                                            done_o, err_o, cfg_locked_o}, 7'b0);
                @(negedge clk);
                rst_i = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("idle_after_abort", {busy_o, cfg_locked_o}, 2'b00);

        // Full reload after the abort.
        run_seq(0, 1'b1, 1'b0, t0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
